// File: rtl/johnson_decoder_monitor.sv
// Receive-side monitor for an N-bit Johnson counter: decodes each sampled code to its
// index, flags non-Johnson patterns and tracks forward-sequence lock with an error count.
module johnson_decoder_monitor #(
    parameter int N        = 4,
    parameter int IDXW     = 3,
    parameter int LOCK_CNT = 2,
    parameter int ERRW     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [N-1:0]    code_in,
    input  logic            err_clr,
    output logic            idx_valid,
    output logic [IDXW-1:0] idx_out,
    output logic            legal,
    output logic            locked,
    output logic            seq_err,
    output logic [ERRW-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam int              GW          = $clog2(LOCK_CNT + 1);
    localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(2 * N - 1);
    localparam logic [GW-1:0]   LOCK_TARGET = GW'(LOCK_CNT);

    // Returns {legal, index}; a code is legal only if it equals the thermometer
    // pattern implied by its own popcount and MSB.
    function automatic logic [IDXW:0] johnson_decode(input logic [N-1:0] code);
        int            pc;
        int            idx;
        logic          ok;
        logic [N-1:0]  low_pat;
        logic [N-1:0]  high_pat;
        pc = 0;
        for (int b = 0; b < N; b++) begin
            pc = pc + int'(code[b]);
        end
        for (int b = 0; b < N; b++) begin
            low_pat[b]  = (b < pc);
            high_pat[b] = (b >= (N - pc));
        end
        if (code[N-1] == 1'b0) begin
            ok  = (code == low_pat);
            idx = pc;
        end else begin
            ok  = (code == high_pat);
            idx = 2 * N - pc;
        end
        if (!ok) begin
            idx = 0;
        end else begin
            idx = idx;
        end
        return {ok, IDXW'(idx)};
    endfunction

    state_t            state_r;
    logic [IDXW-1:0]   prev_idx_r;
    logic [GW-1:0]     good_cnt_r;
    logic              idx_valid_r;
    logic [IDXW-1:0]   idx_out_r;
    logic              legal_r;
    logic              locked_r;
    logic              seq_err_r;
    logic [ERRW-1:0]   err_count_r;

    logic [IDXW:0]     dec_s;
    logic              dec_legal_s;
    logic [IDXW-1:0]   dec_idx_s;
    logic [IDXW-1:0]   succ_idx_s;
    logic              is_succ_s;
    logic              is_repeat_s;
    logic              violation_s;
    logic [GW-1:0]     good_inc_s;
    logic              err_inc_s;
    logic              err_sat_s;

    // Decode the incoming code and classify it against the previous accepted index.
    always_comb begin
        dec_s       = johnson_decode(code_in);
        dec_legal_s = dec_s[IDXW];
        dec_idx_s   = dec_s[IDXW-1:0];
        succ_idx_s  = (prev_idx_r == LAST_IDX) ? {IDXW{1'b0}} : (prev_idx_r + IDXW'(1));
        is_succ_s   = dec_legal_s && (dec_idx_s == succ_idx_s);
        is_repeat_s = dec_legal_s && (dec_idx_s == prev_idx_r);
        violation_s = !(is_succ_s || is_repeat_s);
        good_inc_s  = good_cnt_r + GW'(1);
        err_inc_s   = in_valid && (state_r == ST_LOCKED) && violation_s;
        err_sat_s   = (err_count_r == {ERRW{1'b1}});
    end

    // Sample register, lock FSM and saturating error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_UNLOCKED;
            prev_idx_r  <= {IDXW{1'b0}};
            good_cnt_r  <= {GW{1'b0}};
            idx_valid_r <= 1'b0;
            idx_out_r   <= {IDXW{1'b0}};
            legal_r     <= 1'b0;
            locked_r    <= 1'b0;
            seq_err_r   <= 1'b0;
            err_count_r <= {ERRW{1'b0}};
        end else begin
            seq_err_r   <= 1'b0;
            idx_valid_r <= in_valid;

            // Clear beats a coincident increment.
            if (err_clr) begin
                err_count_r <= {ERRW{1'b0}};
            end else if (err_inc_s && !err_sat_s) begin
                err_count_r <= err_count_r + ERRW'(1);
            end else begin
                err_count_r <= err_count_r;
            end

            if (in_valid) begin
                idx_out_r <= dec_idx_s;
                legal_r   <= dec_legal_s;
                case (state_r)
                    ST_UNLOCKED: begin
                        if (dec_legal_s) begin
                            prev_idx_r <= dec_idx_s;
                            good_cnt_r <= {GW{1'b0}};
                            state_r    <= ST_ACQUIRE;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (!dec_legal_s) begin
                            state_r <= ST_UNLOCKED;
                        end else if (is_succ_s) begin
                            prev_idx_r <= dec_idx_s;
                            good_cnt_r <= good_inc_s;
                            if (good_inc_s == LOCK_TARGET) begin
                                state_r  <= ST_LOCKED;
                                locked_r <= 1'b1;
                            end
                        end else if (!is_repeat_s) begin
                            prev_idx_r <= dec_idx_s;
                            good_cnt_r <= {GW{1'b0}};
                        end
                    end
                    ST_LOCKED: begin
                        if (violation_s) begin
                            seq_err_r <= 1'b1;
                            state_r   <= ST_UNLOCKED;
                            locked_r  <= 1'b0;
                        end else if (is_succ_s) begin
                            prev_idx_r <= dec_idx_s;
                        end
                    end
                    default: begin
                        state_r  <= ST_UNLOCKED;
                        locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign idx_valid = idx_valid_r;
    assign idx_out   = idx_out_r;
    assign legal     = legal_r;
    assign locked    = locked_r;
    assign seq_err   = seq_err_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// Scoreboard bench: two monitors (ERRW=8 and ERRW=2) share stimulus; a table-driven
// reference model pushes expected outputs per edge, each test pops and compares.
module tb_johnson_decoder_monitor;

    localparam int N = 4;
    localparam int IDXW = 3;
    localparam int LOCK_CNT = 2;

    typedef logic [23:0] vec_t;

    logic clk = 1'b0;
    logic reset, in_valid, err_clr;
    logic [N-1:0] code_in;

    logic idx_valid, legal, locked, seq_err;
    logic [IDXW-1:0] idx_out;
    logic [7:0] err_count;
    logic s_idx_valid, s_legal, s_locked, s_seq_err;
    logic [IDXW-1:0] s_idx_out;
    logic [1:0] s_err_count;

    int total = 0;
    int bad = 0;
    vec_t sb_q[$];

    // reference model state
    logic [3:0] jc [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    int m_state = 0, m_prev = 0, m_good = 0;
    logic m_valid = 1'b0, m_legal = 1'b0, m_locked = 1'b0, m_seq = 1'b0;
    logic [2:0] m_idx = 3'd0;
    logic [7:0] m_err8 = 8'd0;
    logic [1:0] m_err2 = 2'd0;

    johnson_decoder_monitor #(.N(N), .IDXW(IDXW), .LOCK_CNT(LOCK_CNT), .ERRW(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .code_in(code_in), .err_clr(err_clr),
        .idx_valid(idx_valid), .idx_out(idx_out), .legal(legal), .locked(locked),
        .seq_err(seq_err), .err_count(err_count)
    );

    johnson_decoder_monitor #(.N(N), .IDXW(IDXW), .LOCK_CNT(LOCK_CNT), .ERRW(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .code_in(code_in), .err_clr(err_clr),
        .idx_valid(s_idx_valid), .idx_out(s_idx_out), .legal(s_legal), .locked(s_locked),
        .seq_err(s_seq_err), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t obs();
        return {idx_valid, idx_out, legal, locked, seq_err, err_count,
                s_idx_valid, s_idx_out, s_legal, s_locked, s_seq_err, s_err_count};
    endfunction

    task automatic model(input logic v, input logic [3:0] c, input logic clr, input logic rst);
        int di;
        bit dl, succ, rep;
        m_seq = 1'b0;
        if (rst) begin
            m_state = 0; m_prev = 0; m_good = 0;
            m_valid = 1'b0; m_legal = 1'b0; m_locked = 1'b0; m_idx = 3'd0;
            m_err8 = 8'd0; m_err2 = 2'd0;
            return;
        end
        di = 0; dl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (c == jc[i]) begin dl = 1'b1; di = i; end
        end
        m_valid = v;
        if (clr) begin m_err8 = 8'd0; m_err2 = 2'd0; end
        if (v) begin
            m_idx = 3'(di);
            m_legal = dl;
            succ = dl && (di == (m_prev + 1) % 8);
            rep = dl && (di == m_prev);
            case (m_state)
                0: if (dl) begin m_prev = di; m_good = 0; m_state = 1; end
                1: begin
                    if (!dl) m_state = 0;
                    else if (succ) begin
                        m_good++; m_prev = di;
                        if (m_good == LOCK_CNT) m_state = 2;
                    end else if (!rep) begin m_prev = di; m_good = 0; end
                end
                default: begin
                    if (succ) m_prev = di;
                    else if (!rep) begin
                        m_seq = 1'b1; m_state = 0;
                        if (!clr) begin
                            if (m_err8 != 8'hFF) m_err8 = m_err8 + 8'd1;
                            if (m_err2 != 2'd3) m_err2 = m_err2 + 2'd1;
                        end
                    end
                end
            endcase
        end
        m_locked = (m_state == 2);
    endtask

    // Drive one edge worth of stimulus, record the expectation, sample #1 after the edge.
    task automatic step(input logic v, input logic [3:0] c, input logic clr, input logic rst);
        in_valid = v; code_in = c; err_clr = clr; reset = rst;
        model(v, c, clr, rst);
        sb_q.push_back({m_valid, m_idx, m_legal, m_locked, m_seq, m_err8,
                        m_valid, m_idx, m_legal, m_locked, m_seq, m_err2});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t want;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'h7, 1'b0, 1'b1);
            want = sb_q.pop_front();
            total++;
            if (obs() !== want) begin bad++; $display("FAIL reset got=%h want=%h", obs(), want); end
        end
        total++;
        if ({idx_valid, locked, err_count} !== 10'd0) begin
            bad++; $display("FAIL reset_zero got=%b want=0", {idx_valid, locked, err_count});
        end
    endtask

    task automatic test_sequence();
        vec_t want;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, jc[i], 1'b0, 1'b0);
            want = sb_q.pop_front();
            total++;
            if (obs() !== want) begin bad++; $display("FAIL seq[%0d] got=%h want=%h", i, obs(), want); end
            total++;
            if ({idx_out, legal, locked, seq_err} !== {3'(i), 1'b1, (i >= 2), 1'b0}) begin
                bad++;
                $display("FAIL seq_fields[%0d] got idx=%0d legal=%b locked=%b seq_err=%b", i, idx_out, legal, locked, seq_err);
            end
        end
    endtask

    task automatic test_wrap();
        vec_t want;
        logic [3:0] codes [3] = '{4'h8, 4'h0, 4'h1};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, codes[i], 1'b0, 1'b0);
            want = sb_q.pop_front();
            total++;
            if (obs() !== want) begin bad++; $display("FAIL wrap[%0d] got=%h want=%h", i, obs(), want); end
        end
        total++;
        if (locked !== 1'b1 || err_count !== 8'd0) begin
            bad++; $display("FAIL wrap_lock got locked=%b err=%0d want locked=1 err=0", locked, err_count);
        end
    endtask

    task automatic test_skip();
        vec_t want;
        logic [3:0] codes [5] = '{4'h3, 4'hF, 4'h7, 4'hF, 4'hE};
        logic [4:0] seq_exp = 5'b00010;
        logic [4:0] lock_exp = 5'b10001;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, codes[i], 1'b0, 1'b0);
            want = sb_q.pop_front();
            total++;
            if (obs() !== want) begin bad++; $display("FAIL skip[%0d] got=%h want=%h", i, obs(), want); end
            total++;
            if (seq_err !== seq_exp[i] || locked !== lock_exp[i]) begin
                bad++;
                $display("FAIL skip_flags[%0d] got seq_err=%b locked=%b want %b %b", i, seq_err, locked, seq_exp[i], lock_exp[i]);
            end
        end
        total++;
        if (err_count !== 8'd1) begin bad++; $display("FAIL skip_count got=%0d want=1", err_count); end
    endtask

    task automatic test_illegal();
        vec_t want;
        logic [1:0] seq_exp = 2'b01;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'h5, 1'b0, 1'b0);
            want = sb_q.pop_front();
            total++;
            if (obs() !== want) begin bad++; $display("FAIL illegal[%0d] got=%h want=%h", i, obs(), want); end
            total++;
            if (legal !== 1'b0 || idx_out !== 3'd0 || seq_err !== seq_exp[i] || err_count !== 8'd2) begin
                bad++;
                $display("FAIL illegal_fields[%0d] got legal=%b idx=%0d seq_err=%b err=%0d", i, legal, idx_out, seq_err, err_count);
            end
        end
    endtask

    task automatic test_stall();
        vec_t want;
        logic [3:0] codes [9] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'h7, 4'h7, 4'h5, 4'h5, 4'hF};
        logic [8:0] vld = 9'b100111111;
        for (int i = 0; i < 9; i++) begin
            step(vld[i], codes[i], 1'b0, 1'b0);
            want = sb_q.pop_front();
            total++;
            if (obs() !== want) begin bad++; $display("FAIL stall[%0d] got=%h want=%h", i, obs(), want); end
            if (i >= 2) begin
                total++;
                if (idx_valid !== vld[i] || locked !== 1'b1 || seq_err !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_flags[%0d] got valid=%b locked=%b seq_err=%b", i, idx_valid, locked, seq_err);
                end
            end
        end
        total++;
        if (idx_out !== 3'd4 || err_count !== 8'd2) begin
            bad++; $display("FAIL stall_end got idx=%0d err=%0d want 4 2", idx_out, err_count);
        end
    endtask

    task automatic test_saturate();
        vec_t want;
        int pulses = 0;
        step(1'b0, 4'h0, 1'b0, 1'b1);
        void'(sb_q.pop_front());
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b1, (i == 3) ? 4'h5 : jc[i], (v == 4) && (i == 3), (v == 5) && (i == 3));
                want = sb_q.pop_front();
                total++;
                if (obs() !== want) begin bad++; $display("FAIL sat[%0d.%0d] got=%h want=%h", v, i, obs(), want); end
                if (s_seq_err === 1'b1) pulses++;
            end
            if (v == 3) begin
                total++;
                if (s_err_count !== 2'd3 || err_count !== 8'd4 || pulses != 4) begin
                    bad++;
                    $display("FAIL sat_stop got sat=%0d wide=%0d pulses=%0d want 3 4 4", s_err_count, err_count, pulses);
                end
            end
            if (v == 4) begin
                total++;
                if (err_count !== 8'd0 || s_err_count !== 2'd0 || seq_err !== 1'b1) begin
                    bad++;
                    $display("FAIL clr_wins got err=%0d sat=%0d seq_err=%b want 0 0 1", err_count, s_err_count, seq_err);
                end
            end
        end
        total++;
        if (obs() !== 24'd0) begin bad++; $display("FAIL reset_locked got=%h want=0", obs()); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; err_clr = 1'b0; code_in = 4'h0;
        #1;
        test_reset();
        test_sequence();
        test_wrap();
        test_skip();
        test_illegal();
        test_stall();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/johnson_decoder_monitor.md
Name: johnson_decoder_monitor

Overview:
- Receive-side companion to the team's N-bit Johnson (twisted-ring) counter.
- Samples an incoming Johnson code and registers its binary index (0..2N-1).
- Flags illegal (non-Johnson) codes and verifies that consecutive samples follow the forward sequence 0,1,3,7,F,E,C,8 (for N=4).
- A lock state machine and a saturating error counter sit between the counter under test and the checking or debug logic.

Parameters:
- N, 4, Johnson code width in bits (N >= 2)
- IDXW, 3, index width; must equal ceil(log2(2N))
- LOCK_CNT, 2, consecutive correct successor transitions needed to enter LOCKED (>= 1)
- ERRW, 8, width of the error counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  code_in is sampled on this cycle
- code_in  input  N  Johnson code from the counter
- err_clr  input  1  synchronous clear of err_count
- idx_valid  output  1  idx_out/legal reflect a sample taken on the previous cycle
- idx_out  output  IDXW  decoded index of the last sample
- legal  output  1  last sample was a valid Johnson code
- locked  output  1  FSM is in LOCKED
- seq_err  output  1  one-cycle pulse marking a sequence violation while LOCKED
- err_count  output  ERRW  saturating count of seq_err pulses

Behaviour:
- Reset: already decided as reset reset, synchronous, active-high; clock clk.
  - Reset has priority over all inputs in the same cycle.
  - All outputs go to 0. FSM goes to UNLOCKED. Internal prev_idx and good_cnt go to 0.
- Legal codes are the 2N thermometer patterns.
  - MSB=0: ones contiguous from bit 0; index = popcount. 0000 gives 0, 0111 gives 3.
  - MSB=1: ones contiguous from the MSB; index = 2N - popcount. 1111 gives 4, 1000 gives 7.
  - Any other pattern is illegal: legal=0 and idx_out=0.
- Latency: outputs are registered, 1 cycle.
  - A sample taken with in_valid=1 at edge k appears on idx_out, legal and idx_valid=1 after edge k.
  - in_valid=0 at an edge: idx_valid goes to 0, idx_out and legal hold, FSM and counters hold.
- Successor: succ(i) = (i+1) mod 2N. The wrap from 2N-1 to 0 (1000 to 0000) is a correct successor.
- Repeat: a legal sample equal to prev_idx is a stall. FSM, good_cnt and err_count are unchanged.
- FSM, evaluated only on valid samples:
  - UNLOCKED
    - Legal sample: set prev_idx = idx, good_cnt = 0, go to ACQUIRE.
    - Illegal sample: stay in UNLOCKED.
  - ACQUIRE
    - Legal successor: good_cnt++ and prev_idx = idx. When good_cnt reaches LOCK_CNT, go to LOCKED and assert locked on the same edge.
    - Legal repeat: hold.
    - Other legal value: prev_idx = idx, good_cnt = 0, stay in ACQUIRE.
    - Illegal sample: go to UNLOCKED.
    - seq_err is never asserted outside LOCKED.
  - LOCKED
    - Successor: prev_idx = idx.
    - Repeat: hold.
    - Illegal code or any other index: seq_err=1 for one cycle, err_count++, go to UNLOCKED, locked goes to 0.
- err_count:
  - Saturates at 2^ERRW-1; seq_err still pulses at saturation.
  - err_clr=1 clears err_count to 0. If err_clr and an increment occur together, the clear wins and the result is 0.
- Reset mid-sequence drops locked and idx_valid on the next edge, regardless of in_valid.

Test Plan:
1. Reset, then in_valid=1 for 8 cycles with codes 0,1,3,7,F,E,C,8 -> idx_out 0..7, each 1 cycle after its sample; legal=1 throughout; locked=1 after the 3rd sample's edge (LOCK_CNT=2); seq_err never asserted.
2. While locked, feed 8 then 0, then 1 -> wrap accepted, locked stays 1, err_count=0.
3. While locked, feed 3 then F (skipping 7) -> seq_err pulses for exactly 1 cycle, err_count=1, locked=0, FSM in UNLOCKED; then 7,F,E relocks after 3 samples.
4. Feed illegal 0101 while locked -> legal=0, idx_out=0, seq_err pulses, err_count increments; 0101 while UNLOCKED -> legal=0, no seq_err, no count.
5. While locked, hold code 7 for 3 valid cycles, then toggle in_valid=0 for 2 cycles, then feed F -> no error, idx_valid low only during the gap, locked stays 1.
6. With ERRW=2, force 4 violations -> err_count stops at 3 with 4 seq_err pulses; then assert err_clr in the same cycle as a violation -> err_count=0; assert reset while locked -> all outputs 0 after the next edge.
